// File: rtl/line_buffer_exchanger.sv
// line_buffer_exchanger: rotates the one-hot-group line write enables
// and generates line-buffer write addresses for the conv datapath.
module line_buffer_exchanger #(
  parameter int NUM_LINES = 32,
  parameter int ADDR_W    = 8,
  parameter int SLIDE_W   = 9,
  parameter int CH_W      = 6,
  parameter int ROW_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [SLIDE_W-1:0]   cfg_num_slide,
  input  logic [CH_W-1:0]      cfg_inch_grp,
  input  logic [CH_W-1:0]      cfg_ouch_grp,
  input  logic                 cfg_pad,
  input  logic [1:0]           cfg_rot_step,
  input  logic [1:0]           cfg_init_lines,
  input  logic [ROW_W-1:0]     cfg_num_rows,
  input  logic                 start,
  input  logic                 step,
  input  logic                 layer_abort,
  input  logic                 accum_en,
  input  logic                 fill_en,
  output logic [NUM_LINES-1:0] ex_we,
  output logic [NUM_LINES-1:0] ex_we_pad,
  output logic [ADDR_W-1:0]    ex_addr,
  output logic                 addr_valid,
  output logic                 switch_done,
  output logic                 layer_done,
  output logic                 busy,
  output logic                 cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic [SLIDE_W-1:0]   c_slide, slide_cnt;
  logic [CH_W-1:0]      c_inch, c_ouch;
  logic [CH_W-1:0]      inch_cnt, ouch_cnt;
  logic                 c_pad;
  logic [1:0]           c_rot, c_init, rot_amt;
  logic [ROW_W-1:0]     c_rows, row_cnt;
  logic [NUM_LINES-1:0] we_ring, pad_ring, init_mask;
  logic [63:0]          ld_span;
  logic [ADDR_W-1:0]    pitch, addr_calc;
  logic                 ld_err, adv, qual;
  logic                 inch_wrap, ouch_wrap, slide_wrap;
  logic                 sw, last, go, leave;

  function automatic logic [NUM_LINES-1:0] rotl(
    input logic [NUM_LINES-1:0] v,
    input logic [1:0]           n
  );
    return (v << n) | (v >> (NUM_LINES - int'(n)));
  endfunction

  assign ld_span = (64'(cfg_num_slide) + 64'd1 + 64'(cfg_pad))
                 * (64'(cfg_ouch_grp) + 64'd1);
  assign ld_err  = (ld_span > (64'd1 << ADDR_W))
                 || (int'({30'd0, cfg_init_lines}) > NUM_LINES);

  assign busy    = (state == RUN);
  assign qual    = accum_en | fill_en;
  assign adv     = busy & step & ~layer_abort;
  assign rot_amt = (c_rot == 2'd0) ? 2'd1 : c_rot;

  assign inch_wrap  = (inch_cnt == c_inch);
  assign ouch_wrap  = (ouch_cnt == c_ouch);
  assign slide_wrap = (slide_cnt == c_slide);
  assign sw   = adv & inch_wrap & ouch_wrap & slide_wrap;
  assign last = sw & (row_cnt == c_rows);
  assign go    = (state == IDLE) & (state_nxt == RUN);
  assign leave = (state == RUN) & (state_nxt == IDLE);

  assign pitch = ADDR_W'(c_slide) + ADDR_W'(1) + ADDR_W'(c_pad);
  assign addr_calc = ADDR_W'(slide_cnt) + pitch * ADDR_W'(ouch_cnt);

  assign ex_we     = we_ring & {NUM_LINES{qual}};
  assign ex_we_pad = pad_ring;

  // initial ring: lowest max(init_lines,1) lines enabled
  always_comb begin
    init_mask = '0;
    unique case (c_init)
      2'd2:    init_mask = NUM_LINES'(3);
      2'd3:    init_mask = NUM_LINES'(7);
      default: init_mask = NUM_LINES'(1);
    endcase
  end

  // layer state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // layer next-state: abort and final switch both end the layer
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && !cfg_err && !layer_abort) state_nxt = RUN;
      RUN:  if (layer_abort || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // config capture, only while idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      c_slide <= '0;
      c_inch  <= '0;
      c_ouch  <= '0;
      c_pad   <= 1'b0;
      c_rot   <= '0;
      c_init  <= '0;
      c_rows  <= '0;
      cfg_err <= 1'b0;
    end else if (state == IDLE && cfg_load) begin
      c_slide <= cfg_num_slide;
      c_inch  <= cfg_inch_grp;
      c_ouch  <= cfg_ouch_grp;
      c_pad   <= cfg_pad;
      c_rot   <= cfg_rot_step;
      c_init  <= cfg_init_lines;
      c_rows  <= cfg_num_rows;
      cfg_err <= ld_err;
    end
  end

  // nested window counters: inch inner, ouch middle, slide outer
  always_ff @(posedge clk) begin
    if (!rst || state_nxt != RUN || go) begin
      inch_cnt  <= '0;
      ouch_cnt  <= '0;
      slide_cnt <= '0;
      row_cnt   <= '0;
    end else if (adv) begin
      if (inch_wrap) begin
        inch_cnt <= '0;
        if (ouch_wrap) begin
          ouch_cnt <= '0;
          if (slide_wrap) slide_cnt <= '0;
          else            slide_cnt <= slide_cnt + 1'b1;
        end else begin
          ouch_cnt <= ouch_cnt + 1'b1;
        end
      end else begin
        inch_cnt <= inch_cnt + 1'b1;
      end
      if (sw) row_cnt <= row_cnt + 1'b1;
    end
  end

  // enable rings: seed on start, rotate on switch, clear on exit
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_ring  <= '0;
      pad_ring <= '0;
    end else if (go) begin
      we_ring  <= init_mask;
      pad_ring <= init_mask;
    end else if (leave) begin
      we_ring  <= '0;
      pad_ring <= '0;
    end else if (sw) begin
      we_ring  <= rotl(we_ring, rot_amt);
      pad_ring <= rotl(pad_ring, rot_amt);
    end
  end

  // registered address, valid flag and event pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_addr     <= '0;
      addr_valid  <= 1'b0;
      switch_done <= 1'b0;
      layer_done  <= 1'b0;
    end else begin
      ex_addr     <= addr_calc;
      addr_valid  <= busy & qual;
      switch_done <= sw;
      layer_done  <= last;
    end
  end

endmodule

// File: tb/tb_line_buffer_exchanger.sv
// tb_line_buffer_exchanger: directed checks of ring rotation,
// addressing, config error and abort behaviour.
module tb_line_buffer_exchanger;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [8:0]  cfg_num_slide;
  logic [5:0]  cfg_inch_grp;
  logic [5:0]  cfg_ouch_grp;
  logic        cfg_pad;
  logic [1:0]  cfg_rot_step;
  logic [1:0]  cfg_init_lines;
  logic [9:0]  cfg_num_rows;
  logic        start, step, layer_abort, accum_en, fill_en;

  logic [31:0] we32, pad32;
  logic [7:0]  addr32;
  logic        av32, sd32, ld32, busy32, err32;
  logic [7:0]  we8, pad8;
  logic [7:0]  addr8;
  logic        av8, sd8, ld8, busy8, err8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  line_buffer_exchanger u_dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .cfg_num_slide(cfg_num_slide), .cfg_inch_grp(cfg_inch_grp),
    .cfg_ouch_grp(cfg_ouch_grp), .cfg_pad(cfg_pad),
    .cfg_rot_step(cfg_rot_step), .cfg_init_lines(cfg_init_lines),
    .cfg_num_rows(cfg_num_rows), .start(start), .step(step),
    .layer_abort(layer_abort), .accum_en(accum_en), .fill_en(fill_en),
    .ex_we(we32), .ex_we_pad(pad32), .ex_addr(addr32),
    .addr_valid(av32), .switch_done(sd32), .layer_done(ld32),
    .busy(busy32), .cfg_err(err32)
  );

  line_buffer_exchanger #(.NUM_LINES(8)) u_dut8 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .cfg_num_slide(cfg_num_slide), .cfg_inch_grp(cfg_inch_grp),
    .cfg_ouch_grp(cfg_ouch_grp), .cfg_pad(cfg_pad),
    .cfg_rot_step(cfg_rot_step), .cfg_init_lines(cfg_init_lines),
    .cfg_num_rows(cfg_num_rows), .start(start), .step(step),
    .layer_abort(layer_abort), .accum_en(accum_en), .fill_en(fill_en),
    .ex_we(we8), .ex_we_pad(pad8), .ex_addr(addr8),
    .addr_valid(av8), .switch_done(sd8), .layer_done(ld8),
    .busy(busy8), .cfg_err(err8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input int slide, input int inch,
                          input int ouch, input int pad,
                          input int rot, input int init,
                          input int rows);
    cfg_num_slide  = 9'(slide);
    cfg_inch_grp   = 6'(inch);
    cfg_ouch_grp   = 6'(ouch);
    cfg_pad        = 1'(pad);
    cfg_rot_step   = 2'(rot);
    cfg_init_lines = 2'(init);
    cfg_num_rows   = 10'(rows);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic do_abort();
    layer_abort = 1'b1;
    tick();
    layer_abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (we32 !== 32'h0 || pad32 !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rings: we=%h pad=%h required 0", we32, pad32);
    end
    n_cmp++;
    if ({addr32, av32, sd32, ld32, busy32, err32} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_outs: addr=%h av=%b sd=%b ld=%b busy=%b err=%b required 0",
               addr32, av32, sd32, ld32, busy32, err32);
    end
    n_cmp++;
    if ({we8, pad8, busy8} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_dut8: we=%h pad=%h busy=%b required 0", we8, pad8, busy8);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_defaults();
    logic [31:0] exp_we;
    fill_en = 1'b1;
    load_cfg(2, 0, 0, 0, 2, 2, 3);
    do_start();
    n_cmp++;
    if (busy32 !== 1'b1 || we32 !== 32'h3) begin
      n_bad++;
      $display("FAIL def_start: busy=%b we=%h required 1 / 3", busy32, we32);
    end
    for (int i = 1; i <= 12; i++) begin
      do_step();
      n_cmp++;
      if (sd32 !== (i % 3 == 0)) begin
        n_bad++;
        $display("FAIL def_switch step %0d: switch_done=%b", i, sd32);
      end
      if (i % 3 == 0 && i < 12) begin
        exp_we = 32'h3 << (2 * (i / 3));
        n_cmp++;
        if (we32 !== exp_we) begin
          n_bad++;
          $display("FAIL def_ring step %0d: we=%h required %h", i, we32, exp_we);
        end
      end
    end
    n_cmp++;
    if (ld32 !== 1'b1 || busy32 !== 1'b0 || we32 !== 32'h0) begin
      n_bad++;
      $display("FAIL def_layer_done: ld=%b busy=%b we=%h required 1/0/0",
               ld32, busy32, we32);
    end
    tick();
    n_cmp++;
    if (ld32 !== 1'b0) begin
      n_bad++;
      $display("FAIL def_ld_pulse: layer_done=%b required 0", ld32);
    end
    fill_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] wexp [3];
    wexp = '{8'h38, 8'hC1, 8'h0E};
    fill_en = 1'b1;
    load_cfg(0, 0, 0, 0, 3, 3, 5);
    do_start();
    n_cmp++;
    if (we8 !== 8'h07) begin
      n_bad++;
      $display("FAIL wrap_init: we=%h required 07", we8);
    end
    for (int k = 0; k < 3; k++) begin
      do_step();
      n_cmp++;
      if (we8 !== wexp[k] || sd8 !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap_ring %0d: we=%h sd=%b required %h / 1",
                 k, we8, sd8, wexp[k]);
      end
      n_cmp++;
      if ($countones(pad8) != 3) begin
        n_bad++;
        $display("FAIL wrap_popcount %0d: pad=%h required 3 ones", k, pad8);
      end
    end
    n_cmp++;
    if (we32 !== 32'h0000_0E00) begin
      n_bad++;
      $display("FAIL wrap_wide: we=%h required 00000e00", we32);
    end
    do_abort();
    n_cmp++;
    if (busy8 !== 1'b0 || we8 !== 8'h0) begin
      n_bad++;
      $display("FAIL wrap_abort: busy=%b we=%h required 0", busy8, we8);
    end
    fill_en = 1'b0;
  endtask

  task automatic test_addressing();
    logic [7:0] aexp [8];
    logic [7:0] prev;
    aexp = '{8'd0, 8'd5, 8'd5, 8'd10, 8'd10, 8'd1, 8'd1, 8'd6};
    accum_en = 1'b1;
    load_cfg(3, 1, 2, 1, 1, 1, 3);
    do_start();
    tick();
    n_cmp++;
    if (addr32 !== 8'd0 || av32 !== 1'b1) begin
      n_bad++;
      $display("FAIL addr_first: addr=%0d av=%b required 0 / 1", addr32, av32);
    end
    prev = 8'd0;
    for (int k = 0; k < 8; k++) begin
      do_step();
      n_cmp++;
      if (addr32 !== prev) begin
        n_bad++;
        $display("FAIL addr_latency %0d: addr=%0d required %0d", k, addr32, prev);
      end
      tick();
      n_cmp++;
      if (addr32 !== aexp[k]) begin
        n_bad++;
        $display("FAIL addr_seq %0d: addr=%0d required %0d", k, addr32, aexp[k]);
      end
      prev = aexp[k];
    end
    do_abort();
    accum_en = 1'b0;
  endtask

  task automatic test_cfg_err();
    load_cfg(99, 0, 2, 1, 1, 1, 0);
    n_cmp++;
    if (err32 !== 1'b1) begin
      n_bad++;
      $display("FAIL cfgerr_set: cfg_err=%b required 1", err32);
    end
    do_start();
    do_step();
    n_cmp++;
    if (busy32 !== 1'b0 || sd32 !== 1'b0) begin
      n_bad++;
      $display("FAIL cfgerr_start: busy=%b sd=%b required 0", busy32, sd32);
    end
    load_cfg(127, 0, 1, 0, 1, 1, 0);
    n_cmp++;
    if (err32 !== 1'b0) begin
      n_bad++;
      $display("FAIL cfgerr_edge256: cfg_err=%b required 0", err32);
    end
    load_cfg(127, 0, 1, 1, 1, 1, 0);
    n_cmp++;
    if (err32 !== 1'b1) begin
      n_bad++;
      $display("FAIL cfgerr_edge258: cfg_err=%b required 1", err32);
    end
  endtask

  task automatic test_abort_collision();
    fill_en = 1'b1;
    load_cfg(0, 0, 1, 0, 1, 1, 3);
    do_start();
    do_step();
    n_cmp++;
    if (sd32 !== 1'b0 || busy32 !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre: sd=%b busy=%b required 0 / 1", sd32, busy32);
    end
    step = 1'b1;
    layer_abort = 1'b1;
    tick();
    step = 1'b0;
    layer_abort = 1'b0;
    n_cmp++;
    if (sd32 !== 1'b0 || busy32 !== 1'b0 || we32 !== 32'h0 || pad32 !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_collide: sd=%b busy=%b we=%h pad=%h required 0",
               sd32, busy32, we32, pad32);
    end
    tick();
    n_cmp++;
    if (sd32 !== 1'b0 || ld32 !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_after: sd=%b ld=%b required 0", sd32, ld32);
    end
    fill_en = 1'b0;
  endtask

  task automatic test_qualification();
    accum_en = 1'b0;
    fill_en  = 1'b0;
    load_cfg(1, 0, 0, 0, 0, 2, 3);
    do_start();
    n_cmp++;
    if (we32 !== 32'h0 || pad32 !== 32'h3) begin
      n_bad++;
      $display("FAIL qual_we: we=%h pad=%h required 0 / 3", we32, pad32);
    end
    tick();
    n_cmp++;
    if (av32 !== 1'b0) begin
      n_bad++;
      $display("FAIL qual_av: addr_valid=%b required 0", av32);
    end
    load_cfg(99, 0, 2, 1, 1, 1, 0);
    n_cmp++;
    if (err32 !== 1'b0) begin
      n_bad++;
      $display("FAIL qual_runload: cfg_err=%b required 0", err32);
    end
    do_step();
    do_step();
    n_cmp++;
    if (pad32 !== 32'h6 || we32 !== 32'h0 || sd32 !== 1'b1) begin
      n_bad++;
      $display("FAIL qual_rot0: pad=%h we=%h sd=%b required 6 / 0 / 1",
               pad32, we32, sd32);
    end
    fill_en = 1'b1;
    #1;
    n_cmp++;
    if (we32 !== 32'h6) begin
      n_bad++;
      $display("FAIL qual_fill: we=%h required 6", we32);
    end
    tick();
    n_cmp++;
    if (av32 !== 1'b1) begin
      n_bad++;
      $display("FAIL qual_av_fill: addr_valid=%b required 1", av32);
    end
    do_start();
    n_cmp++;
    if (pad32 !== 32'h6 || busy32 !== 1'b1) begin
      n_bad++;
      $display("FAIL qual_start_busy: pad=%h busy=%b required 6 / 1",
               pad32, busy32);
    end
    do_abort();
    fill_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cfg_load = 1'b0;
    cfg_num_slide = '0;
    cfg_inch_grp = '0;
    cfg_ouch_grp = '0;
    cfg_pad = 1'b0;
    cfg_rot_step = '0;
    cfg_init_lines = '0;
    cfg_num_rows = '0;
    start = 1'b0;
    step = 1'b0;
    layer_abort = 1'b0;
    accum_en = 1'b0;
    fill_en = 1'b0;
    test_reset();
    test_defaults();
    test_wrap();
    test_addressing();
    test_cfg_err();
    test_abort_collision();
    test_qualification();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
